apb_slave_bridge: RTL and testbench

Parametrised APB4 slave bridge with wait-state and error support, sitting between the peripheral APB fabric and a peripheral's native register bus. Unlike a zero-wait adapter, it launches a registered native request, stretches the APB access phase with PREADY until the native side acknowledges, and returns PSLVERR on any of these conditions:

- address out of range
- protection violation
- illegal read strobes
- native-side error
- timeout

A sticky error-cause register supports debug.

---
 rtl/apb_bridge_pkg.sv | 26 ++
 rtl/apb_timeout_ctr.sv | 51 +++++
 rtl/apb_slave_bridge.sv | 164 ++++++++++++++++
 tb/tb_apb_slave_bridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_bridge_pkg
// Description : Shared types for the APB4 slave bridge: FSM state encoding
//               and the error-cause codes reported on last_err.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } bridge_state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_RANGE   = 3'd1,
        ERR_PROT    = 3'd2,
        ERR_STRB    = 3'd3,
        ERR_TIMEOUT = 3'd4,
        ERR_SLAVE   = 3'd5
    } err_cause_t;

endpackage
`default_nettype wire

// File: rtl/apb_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : apb_timeout_ctr
// Description : Wait-cycle counter for the native request phase. Counts
//               enabled cycles and flags expiry on the cycle that reaches
//               TIMEOUT_CYCLES. The count saturates and never wraps.
//               TIMEOUT_CYCLES=0 disables the timeout (expired tied low).
// Ports       : pclk, presetn (sync, active-low)
//               clear   - restart counting from zero
//               enable  - count this cycle
//               expired - this enabled cycle is the TIMEOUT_CYCLES-th one
// Revision    : 1.0 - initial release
// ============================================================================
module apb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic w_unused_inputs;
            assign w_unused_inputs = &{1'b0, pclk, presetn, clear, enable};
            assign expired         = 1'b0;
        end else begin : g_enabled
            localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);
            localparam logic [C_CNT_W-1:0] C_MAX  = C_CNT_W'(TIMEOUT_CYCLES);

            logic [C_CNT_W-1:0] r_count;

            always_ff @(posedge pclk) begin
                if (!presetn || clear) begin
                    r_count <= '0;
                end else if (enable && (r_count != C_MAX)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Expiry is flagged while the final permitted cycle is in
            // progress so the owner can leave on the same edge.
            assign expired = enable && (r_count == C_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_bridge
// Description : APB4 slave to native register-bus bridge. Decodes setup
//               phase errors (range, protection, read strobes), launches a
//               registered native request, stretches the access phase until
//               reg_ready or timeout, and reports PSLVERR with a sticky cause.
// Ports       : APB   - pclk, presetn, paddr, pprot, psel, penable, pwrite,
//                       pwdata, pstrb, prdata, pready, pslverr
//               Native- reg_req, reg_addr, reg_wdata, reg_we, reg_be,
//                       reg_rdata, reg_ready, reg_err
//               Debug - last_err (err_cause_t)
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_bridge
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RANGE_BYTES    = 4096,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int SECURE_ONLY    = 0
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [2:0]              pprot,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic                    reg_req,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic                    reg_we,
    output logic [DATA_WIDTH/8-1:0] reg_be,
    input  logic [DATA_WIDTH-1:0]   reg_rdata,
    input  logic                    reg_ready,
    input  logic                    reg_err,
    output logic [2:0]              last_err
);

    localparam logic [ADDR_WIDTH-1:0] C_RANGE = ADDR_WIDTH'(RANGE_BYTES);

    bridge_state_t r_state;
    bridge_state_t w_state_next;
    err_cause_t    w_setup_err;
    err_cause_t    r_last_err;
    logic          w_setup;
    logic          w_expired;
    logic          w_unused_prot;

    // Only the secure/non-secure bit of pprot matters here.
    assign w_unused_prot = &{1'b0, pprot[2], pprot[0]};

    assign w_setup = psel && !penable;

    // Setup-phase checks in priority order: range, protection, strobes.
    always_comb begin
        w_setup_err = ERR_NONE;
        if (paddr >= C_RANGE) begin
            w_setup_err = ERR_RANGE;
        end else if ((SECURE_ONLY != 0) && pprot[1]) begin
            w_setup_err = ERR_PROT;
        end else if (!pwrite && (|pstrb)) begin
            w_setup_err = ERR_STRB;
        end
    end

    apb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (r_state != REQ),
        .enable  ((r_state == REQ) && !reg_ready),
        .expired (w_expired)
    );

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_setup) begin
                    w_state_next = (w_setup_err != ERR_NONE) ? RESP : REQ;
                end
            end
            REQ: begin
                // reg_ready takes precedence over a coincident timeout.
                if (reg_ready || w_expired) begin
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode, so nothing on the
    // APB inputs reaches pready/pslverr combinationally.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            reg_req    <= 1'b0;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            prdata     <= '0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_we     <= 1'b0;
            reg_be     <= '0;
            r_last_err <= ERR_NONE;
        end else begin
            reg_req <= (w_state_next == REQ);
            pready  <= (w_state_next == RESP);
            pslverr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        if (w_setup_err != ERR_NONE) begin
                            pslverr    <= 1'b1;
                            prdata     <= '0;
                            r_last_err <= w_setup_err;
                        end else begin
                            reg_addr  <= paddr;
                            reg_wdata <= pwdata;
                            reg_we    <= pwrite;
                            reg_be    <= pwrite ? pstrb : '1;
                        end
                    end
                end
                REQ: begin
                    if (reg_ready) begin
                        pslverr <= reg_err;
                        prdata  <= (!reg_we && !reg_err) ? reg_rdata : '0;
                        if (reg_err) begin
                            r_last_err <= ERR_SLAVE;
                        end
                    end else if (w_expired) begin
                        pslverr    <= 1'b1;
                        prdata     <= '0;
                        r_last_err <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign last_err = r_last_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_slave_bridge
// Description : Scoreboard bench for apb_slave_bridge. The stimulus task
//               queues expected APB responses and native requests; monitors
//               pop and compare them when the DUT presents pready or raises
//               reg_req. A native responder model answers after a
//               per-transfer delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave_bridge;
    import apb_bridge_pkg::*;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        reg_req;
    logic [31:0] reg_addr, reg_wdata;
    logic        reg_we;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ready, reg_err;
    logic [2:0]  last_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
        logic [2:0]  last;
        int          reqs;
    } resp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
    } nat_exp_t;

    resp_exp_t resp_q[$];
    nat_exp_t  nat_q[$];

    // Native responder configuration, set per transfer (-1 = never ready).
    int          nat_delay = -1;
    logic [31:0] nat_rdata = '0;
    logic        nat_err   = 1'b0;

    apb_slave_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .RANGE_BYTES    (4096),
        .TIMEOUT_CYCLES (16),
        .SECURE_ONLY    (1)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .paddr     (paddr),
        .pprot     (pprot),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .reg_req   (reg_req),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_be    (reg_be),
        .reg_rdata (reg_rdata),
        .reg_ready (reg_ready),
        .reg_err   (reg_err),
        .last_err  (last_err)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Native responder: raises reg_ready on the (nat_delay+1)-th REQ cycle.
    initial begin
        int seen = 0;
        reg_ready = 1'b0;
        reg_err   = 1'b0;
        reg_rdata = '0;
        forever begin
            @(posedge pclk);
            #1;
            if (reg_req) begin
                seen++;
                if (nat_delay >= 0 && seen == nat_delay + 1) begin
                    reg_ready = 1'b1;
                    reg_rdata = nat_rdata;
                    reg_err   = nat_err;
                end else begin
                    reg_ready = 1'b0;
                    reg_err   = 1'b0;
                    reg_rdata = 32'hBAD0_BAD0;
                end
            end else begin
                seen      = 0;
                reg_ready = 1'b0;
                reg_err   = 1'b0;
            end
        end
    end

    // Response monitor: counts reg_req cycles and checks each pready pulse.
    int req_cnt = 0;
    always @(negedge pclk) begin
        if (!presetn) begin
            req_cnt = 0;
        end else begin
            if (reg_req) req_cnt++;
            if (pready) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_pready", 64'(pready), 64'd0);
                end else begin
                    resp_exp_t e;
                    e = resp_q.pop_front();
                    chk("pready_cycle", 64'(cyc), 64'(e.cyc));
                    chk("pslverr",      64'(pslverr), 64'(e.err));
                    chk("prdata",       64'(prdata), 64'(e.rdata));
                    chk("last_err",     64'(last_err), 64'(e.last));
                    chk("req_cycles",   64'(req_cnt), 64'(e.reqs));
                end
                req_cnt = 0;
            end
        end
    end

    // Native-request monitor: checks latched fields when reg_req rises.
    logic req_d = 1'b0;
    always @(negedge pclk) begin
        if (reg_req && !req_d) begin
            if (nat_q.size() == 0) begin
                chk("unexpected_reg_req", 64'(reg_req), 64'd0);
            end else begin
                nat_exp_t n;
                n = nat_q.pop_front();
                chk("reg_addr", 64'(reg_addr), 64'(n.addr));
                chk("reg_we",   64'(reg_we), 64'(n.we));
                chk("reg_be",   64'(reg_be), 64'(n.be));
                if (n.we) chk("reg_wdata", 64'(reg_wdata), 64'(n.wdata));
            end
        end
        req_d = reg_req;
    end

    // One APB transfer. lat is pready cycle relative to setup cycle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot,
                        input int delay, input logic [31:0] rdata, input logic rerr,
                        input int lat, input logic xerr, input logic [31:0] xrdata,
                        input logic [2:0] xlast, input int xreqs, input logic native);
        resp_exp_t e;
        nat_exp_t  n;
        @(posedge pclk);
        #1;
        nat_delay = delay;
        nat_rdata = rdata;
        nat_err   = rerr;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wdata; pstrb = strb; pprot = prot;
        e.cyc = cyc + lat; e.err = xerr; e.rdata = xrdata; e.last = xlast; e.reqs = xreqs;
        resp_q.push_back(e);
        if (native) begin
            n.addr = addr; n.wdata = wdata; n.we = wr; n.be = wr ? strb : 4'hF;
            nat_q.push_back(n);
        end
        @(posedge pclk);
        #1;
        penable = 1'b1;
        for (int i = 0; i < 40 && !pready; i++) begin
            @(posedge pclk);
            #1;
        end
        if (!pready) chk("pready_timeout", 64'(pready), 64'd1);
    endtask

    initial begin
        presetn = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_reg_req",  64'(reg_req), 64'd0);
        chk("rst_pready",   64'(pready), 64'd0);
        chk("rst_pslverr",  64'(pslverr), 64'd0);
        chk("rst_prdata",   64'(prdata), 64'd0);
        chk("rst_last_err", 64'(last_err), 64'd0);
        chk("rst_reg_be",   64'(reg_be), 64'd0);
        presetn = 1'b1;

        //   wr    addr          wdata          strb  prot   dly rdata          rerr lat err xrdata         xlast        reqs nat
        xfer(1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 3'b000, 0, 32'h0,        1'b0, 2, 1'b0, 32'h0,        ERR_NONE,    1,  1'b1);
        xfer(1'b0, 32'h20,       32'h0,        4'h0, 3'b000, 3, 32'h12345678, 1'b0, 5, 1'b0, 32'h12345678, ERR_NONE,    4,  1'b1);
        xfer(1'b0, 32'h1000,     32'h0,        4'h0, 3'b000, 0, 32'h0,        1'b0, 1, 1'b1, 32'h0,        ERR_RANGE,   0,  1'b0);
        xfer(1'b1, 32'h30,       32'h11111111, 4'hF, 3'b010, 0, 32'h0,        1'b0, 1, 1'b1, 32'h0,        ERR_PROT,    0,  1'b0);
        xfer(1'b0, 32'h40,       32'h0,        4'h1, 3'b000, 0, 32'h0,        1'b0, 1, 1'b1, 32'h0,        ERR_STRB,    0,  1'b0);
        xfer(1'b0, 32'h44,       32'h0,        4'h0, 3'b000, -1, 32'h0,       1'b0, 17, 1'b1, 32'h0,       ERR_TIMEOUT, 16, 1'b1);
        xfer(1'b1, 32'h48,       32'hCAFEF00D, 4'h3, 3'b000, 15, 32'h0,       1'b0, 17, 1'b0, 32'h0,       ERR_TIMEOUT, 16, 1'b1);
        xfer(1'b0, 32'h4C,       32'h0,        4'h0, 3'b000, 1, 32'hA5A50F0F, 1'b0, 3, 1'b0, 32'hA5A50F0F, ERR_TIMEOUT, 2,  1'b1);
        xfer(1'b0, 32'hFFC00000, 32'h0,        4'h1, 3'b010, 0, 32'h0,        1'b0, 1, 1'b1, 32'h0,        ERR_RANGE,   0,  1'b0);
        xfer(1'b0, 32'h54,       32'h0,        4'h0, 3'b000, 0, 32'h0000FFFF, 1'b1, 2, 1'b1, 32'h0,        ERR_SLAVE,   1,  1'b1);

        // Reset while a native request is outstanding.
        @(posedge pclk);
        #1;
        nat_delay = -1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h58; pstrb = 4'h0; pprot = 3'b000;
        nat_q.push_back('{addr: 32'h58, wdata: 32'h0, we: 1'b0, be: 4'hF});
        @(posedge pclk);
        #1;
        penable = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        presetn = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge pclk);
        #1;
        chk("midrst_reg_req",  64'(reg_req), 64'd0);
        chk("midrst_last_err", 64'(last_err), 64'd0);
        chk("midrst_pready",   64'(pready), 64'd0);
        chk("midrst_prdata",   64'(prdata), 64'd0);
        chk("midrst_reg_addr", 64'(reg_addr), 64'd0);
        presetn = 1'b1;

        xfer(1'b0, 32'h5C,       32'h0,        4'h0, 3'b000, 0, 32'h87654321, 1'b1, 2, 1'b1, 32'h0,        ERR_SLAVE,   1,  1'b1);

        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0;
        repeat (4) @(posedge pclk);
        #1;
        chk("resp_q_drained", 64'(resp_q.size()), 64'd0);
        chk("nat_q_drained",  64'(nat_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
